// File: rtl/clock_display_pkg.sv
// Shared types and the 7-segment lookup for the clock display path.
package clock_display_pkg;

    typedef enum logic [1:0] {
        DIG_MN_U = 2'd0,
        DIG_MN_T = 2'd1,
        DIG_HR_U = 2'd2,
        DIG_HR_T = 2'd3
    } digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Segment order {g,f,e,d,c,b,a}, active-high; anything above 9 shows a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/clock_display_seg7_decoder.sv
// Combinational BCD to 7-segment decoder with a forced-blank input.
module seg7_decoder
    import clock_display_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank overrides the decoded pattern (leading-zero suppression).
    always_comb begin
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            seg_o = bcd_to_seg(value_i);
        end
    end

endmodule

// File: rtl/clock_display.sv
// Multiplexed 4-digit HH:MM display driver: shadow capture, dead-time scanning,
// colon toggle and set-mode blink, all outputs registered with pin polarity.
module clock_display
    import clock_display_pkg::*;
#(
    parameter int P_SCAN_DIV       = 1000,
    parameter int P_BLANK          = 8,
    parameter int P_BLINK_DIV      = 500000,
    parameter int P_SEG_ACTIVE_LOW = 1,
    parameter int P_DIG_ACTIVE_LOW = 1
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic [3:0] i_HR_U,
    input  logic [1:0] i_HR_T,
    input  logic [3:0] i_MN_U,
    input  logic [2:0] i_MN_T,
    input  logic       i_SEC,
    input  logic       i_SET,
    input  logic       i_VALID,
    output logic [6:0] o_SEG,
    output logic       o_DP,
    output logic [3:0] o_DIG
);

    localparam int SCAN_W  = (P_SCAN_DIV > 2) ? $clog2(P_SCAN_DIV) : 1;
    localparam int BLINK_W = (P_BLINK_DIV > 2) ? $clog2(P_BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(P_SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  BLANK_END  = SCAN_W'(P_BLANK);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(P_BLINK_DIV - 1);
    localparam logic SEG_INV = (P_SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (P_DIG_ACTIVE_LOW != 0);

    logic [3:0]         hr_u_q;
    logic [1:0]         hr_t_q;
    logic [3:0]         mn_u_q;
    logic [2:0]         mn_t_q;
    logic [SCAN_W-1:0]  scan_cnt_q;
    digit_idx_t         idx_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_on_q;
    logic               set_q;
    logic               colon_q;
    logic [6:0]         seg_q;
    logic               dp_q;
    logic [3:0]         dig_q;

    logic [3:0]         digit_val_s;
    logic               lead_blank_s;
    logic [6:0]         dec_seg_s;
    logic               visible_s;
    logic [6:0]         seg_d;
    logic               dp_d;
    logic [3:0]         dig_d;

    // Shadow digits: the output path only ever sees these, never the raw inputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            hr_u_q <= 4'd0;
            hr_t_q <= 2'd0;
            mn_u_q <= 4'd0;
            mn_t_q <= 3'd0;
        end else if (i_VALID || i_SET) begin
            hr_u_q <= i_HR_U;
            hr_t_q <= i_HR_T;
            mn_u_q <= i_MN_U;
            mn_t_q <= i_MN_T;
        end
    end

    // Digit slot timer and scan index.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            scan_cnt_q <= '0;
            idx_q      <= DIG_MN_U;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            idx_q      <= digit_idx_t'(idx_q + 2'd1);
        end else begin
            scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
        end
    end

    // Blink phase restarts visible on entering set mode and stays visible outside it.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            set_q       <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            set_q <= i_SET;
            if (!i_SET || !set_q) begin
                blink_cnt_q <= '0;
                blink_on_q  <= 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Colon: held on through set mode and its exit cycle, otherwise toggled by the seconds tick.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            colon_q <= 1'b0;
        end else if (i_SET || set_q) begin
            colon_q <= 1'b1;
        end else if (i_SEC) begin
            colon_q <= ~colon_q;
        end
    end

    // Select the shadow digit for the current slot.
    always_comb begin
        digit_val_s  = 4'd0;
        lead_blank_s = 1'b0;
        case (idx_q)
            DIG_MN_U: digit_val_s = mn_u_q;
            DIG_MN_T: digit_val_s = {1'b0, mn_t_q};
            DIG_HR_U: digit_val_s = hr_u_q;
            DIG_HR_T: begin
                digit_val_s  = {2'b00, hr_t_q};
                lead_blank_s = (hr_t_q == 2'd0);
            end
            default: begin
                digit_val_s  = 4'd0;
                lead_blank_s = 1'b0;
            end
        endcase
    end

    seg7_decoder u_dec (
        .value_i (digit_val_s),
        .blank_i (lead_blank_s),
        .seg_o   (dec_seg_s)
    );

    // Dead time at slot start and the blink-off phase turn every digit and segment off.
    always_comb begin
        visible_s = (scan_cnt_q >= BLANK_END) && blink_on_q;
        if (visible_s) begin
            dig_d = 4'b0001 << idx_q;
            seg_d = dec_seg_s;
            dp_d  = (idx_q == DIG_HR_U) && colon_q;
        end else begin
            dig_d = 4'b0000;
            seg_d = SEG_BLANK;
            dp_d  = 1'b0;
        end
    end

    // Pin registers; polarity is applied only here.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            seg_q <= {7{SEG_INV}};
            dp_q  <= SEG_INV;
            dig_q <= {4{DIG_INV}};
        end else begin
            seg_q <= seg_d ^ {7{SEG_INV}};
            dp_q  <= dp_d ^ SEG_INV;
            dig_q <= dig_d ^ {4{DIG_INV}};
        end
    end

    assign o_SEG = seg_q;
    assign o_DP  = dp_q;
    assign o_DIG = dig_q;

endmodule

// File: tb/tb_clock_display.sv
// Directed bench for clock_display with short scan/blink periods and active-high pins.
module tb_clock_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hr_u;
    logic [1:0] hr_t;
    logic [3:0] mn_u;
    logic [2:0] mn_t;
    logic       sec;
    logic       set;
    logic       valid;
    logic [6:0] o_seg;
    logic       o_dp;
    logic [3:0] o_dig;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_display #(
        .P_SCAN_DIV       (4),
        .P_BLANK          (1),
        .P_BLINK_DIV      (10),
        .P_SEG_ACTIVE_LOW (0),
        .P_DIG_ACTIVE_LOW (0)
    ) dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_HR_U  (hr_u),
        .i_HR_T  (hr_t),
        .i_MN_U  (mn_u),
        .i_MN_T  (mn_t),
        .i_SEC   (sec),
        .i_SET   (set),
        .i_VALID (valid),
        .o_SEG   (o_seg),
        .o_DP    (o_dp),
        .o_DIG   (o_dig)
    );

    typedef struct {
        logic [1:0] hr_t;
        logic [3:0] hr_u;
        logic [2:0] mn_t;
        logic [3:0] mn_u;
        logic [6:0] e0;
        logic [6:0] e1;
        logic [6:0] e2;
        logic [6:0] e3;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Watch 16 cycles (one full frame) and compare per-digit segments, on-time and colon.
    task automatic observe_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                                 input logic [6:0] e2, input logic [6:0] e3, input logic colon);
        logic [6:0] exp_seg [4];
        logic [6:0] seen    [4];
        int         on_cnt  [4];
        int         dp2_cnt;
        int         d;
        logic       bad_dig;
        logic       dp_other;
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        for (int i = 0; i < 4; i++) begin
            seen[i]   = 7'h7F;
            on_cnt[i] = 0;
        end
        dp2_cnt  = 0;
        bad_dig  = 1'b0;
        dp_other = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step();
            case (o_dig)
                4'b0001: d = 0;
                4'b0010: d = 1;
                4'b0100: d = 2;
                4'b1000: d = 3;
                4'b0000: d = -1;
                default: begin d = -1; bad_dig = 1'b1; end
            endcase
            if (d >= 0) begin
                on_cnt[d]++;
                seen[d] = o_seg;
                if (o_dp && d == 2) dp2_cnt++;
                if (o_dp && d != 2) dp_other = 1'b1;
            end else if (o_dp) begin
                dp_other = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s seg dig%0d", tag, i), 32'(seen[i]), 32'(exp_seg[i]));
            chk($sformatf("%s on-cycles dig%0d", tag, i), on_cnt[i], 32'd3);
        end
        chk($sformatf("%s dig one-hot", tag), 32'(bad_dig), 32'd0);
        chk($sformatf("%s dp in dig2 slot", tag), dp2_cnt, colon ? 32'd3 : 32'd0);
        chk($sformatf("%s dp outside dig2", tag), 32'(dp_other), 32'd0);
    endtask

    initial begin
        int on_a, on_off, on_b, bad_seg, bad_dp;
        logic [6:0] want;

        vecs[0] = '{2'd1, 4'd2, 3'd3, 4'd4,   7'h66, 7'h4F, 7'h5B, 7'h06};
        vecs[1] = '{2'd0, 4'd9, 3'd0, 4'd5,   7'h6D, 7'h3F, 7'h6F, 7'h00};
        vecs[2] = '{2'd0, 4'd9, 3'd0, 4'hC,   7'h40, 7'h3F, 7'h6F, 7'h00};
        vecs[3] = '{2'd2, 4'd3, 3'd5, 4'd9,   7'h6F, 7'h6D, 7'h4F, 7'h5B};
        vecs[4] = '{2'd2, 4'hF, 3'd6, 4'd0,   7'h3F, 7'h7D, 7'h40, 7'h5B};
        vecs[5] = '{2'd1, 4'd8, 3'd4, 4'd7,   7'h07, 7'h66, 7'h7F, 7'h06};

        rst = 1'b1; sec = 1'b0; set = 1'b0; valid = 1'b0;
        hr_u = 4'd0; hr_t = 2'd0; mn_u = 4'd0; mn_t = 3'd0;
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // Reset asserted mid-scan for three clocks.
        rst = 1'b1;
        step(); step(); step();
        chk("reset dig", 32'(o_dig), 32'd0);
        chk("reset seg", 32'(o_seg), 32'd0);
        chk("reset dp", 32'(o_dp), 32'd0);
        rst = 1'b0;
        step();
        chk("post-reset slot0 cycle0 dig", 32'(o_dig), 32'd0);
        step();
        chk("post-reset slot0 cycle1 dig", 32'(o_dig), 32'h1);
        chk("post-reset shadow zero seg", 32'(o_seg), 32'h3F);
        chk("post-reset dp", 32'(o_dp), 32'd0);
        step(); step();
        step();
        chk("slot1 dead-time dig", 32'(o_dig), 32'd0);
        step();
        chk("slot1 cycle1 dig", 32'(o_dig), 32'h2);

        // Table: capture each value with VALID and check a whole frame.
        for (int v = 0; v < 6; v++) begin
            hr_t = vecs[v].hr_t; hr_u = vecs[v].hr_u;
            mn_t = vecs[v].mn_t; mn_u = vecs[v].mn_u;
            valid = 1'b1;
            step();
            valid = 1'b0;
            step();
            observe_frame($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1,
                          vecs[v].e2, vecs[v].e3, 1'b0);
        end

        // New inputs without VALID must not reach the display.
        hr_t = 2'd2; hr_u = 4'd6; mn_t = 3'd7; mn_u = 4'd8;
        step();
        observe_frame("hold", 7'h07, 7'h66, 7'h7F, 7'h06, 1'b0);

        // Two seconds ticks: colon on, then off.
        sec = 1'b1; step(); sec = 1'b0; step();
        observe_frame("sec1", 7'h07, 7'h66, 7'h7F, 7'h06, 1'b1);
        sec = 1'b1; step(); sec = 1'b0; step();
        observe_frame("sec2", 7'h07, 7'h66, 7'h7F, 7'h06, 1'b0);

        // Set mode with 07:45 and no VALID: visible 10, dark 10, visible again.
        hr_t = 2'd0; hr_u = 4'd7; mn_t = 3'd4; mn_u = 4'd5;
        set = 1'b1;
        step();
        on_a = 0; on_off = 0; on_b = 0; bad_seg = 0; bad_dp = 0;
        for (int k = 1; k <= 25; k++) begin
            sec = (k == 5);
            step();
            if (o_dig != 4'b0000) begin
                if (k <= 10) on_a++;
                else if (k <= 20) on_off++;
                else on_b++;
                case (o_dig)
                    4'b0001: want = 7'h6D;
                    4'b0010: want = 7'h66;
                    4'b0100: want = 7'h07;
                    4'b1000: want = 7'h00;
                    default: want = 7'h7F;
                endcase
                if (o_seg !== want) bad_seg++;
                if (o_dp !== (o_dig == 4'b0100)) bad_dp++;
            end
        end
        sec = 1'b0;
        chk("set first window visible", 32'(on_a >= 7), 32'd1);
        chk("set blink-off window dark", on_off, 32'd0);
        chk("set second window visible", 32'(on_b >= 3), 32'd1);
        chk("set segs 07:45", bad_seg, 32'd0);
        chk("set colon forced", bad_dp, 32'd0);
        set = 1'b0;
        step();
        observe_frame("set exit", 7'h6D, 7'h66, 7'h07, 7'h00, 1'b1);
        sec = 1'b1; step(); sec = 1'b0; step();
        observe_frame("after set sec", 7'h6D, 7'h66, 7'h07, 7'h00, 1'b0);

        // VALID and SEC in the same cycle: capture and colon toggle together.
        hr_t = 2'd2; hr_u = 4'd1; mn_t = 3'd5; mn_u = 4'd9;
        valid = 1'b1; sec = 1'b1;
        step();
        valid = 1'b0; sec = 1'b0;
        step();
        observe_frame("valid+sec", 7'h6F, 7'h6D, 7'h06, 7'h5B, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
